// File: rtl/tmr_pkg.sv
// Shared types and constants for the multi-channel timeout timer.
package tmr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tmr_state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tmr_channel.sv
// One timer channel: counter, terminal-count register, run/done FSM.
// Define TMR_OVERRUN_EN to add the sticky ovr flag for ticks missed in DONE.
module tmr_channel
  import tmr_pkg::*;
#(
  parameter int unsigned CW           = 7,
  parameter int unsigned DEFAULT_TERM = 99
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic          clr_done,
  input  logic          term_wr,
  input  logic [CW-1:0] term_data,
`ifdef TMR_OVERRUN_EN
  output logic          ovr,
`endif
  output logic          timeout,
  output logic          done,
  output logic          busy
);

  tmr_state_e    state, state_n;
  logic [CW-1:0] count;
  logic [CW-1:0] term;
  logic          mode_r;
  logic          qual;
  logic          expire;

  assign qual   = (state == RUN) && enable && tick;
  assign expire = qual && (count >= term);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Stop masks start in every state; in DONE a stop is otherwise a no-op.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start && !stop) state_n = RUN;
      RUN: begin
        if (stop)                                   state_n = IDLE;
        else if (start)                             state_n = RUN;
        else if (expire && mode_r == MODE_ONESHOT)  state_n = DONE;
      end
      DONE: begin
        if (start && !stop) state_n = RUN;
        else if (clr_done)  state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      term    <= CW'(DEFAULT_TERM);
      mode_r  <= MODE_PERIODIC;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (term_wr) term <= term_data;
      if (stop) begin
        count <= '0;
      end else if (start) begin
        count  <= '0;
        mode_r <= mode;
      end else if (expire) begin
        count   <= '0;
        timeout <= 1'b1;
      end else if (qual) begin
        count <= count + CW'(1);
      end
    end
  end

`ifdef TMR_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (!rst)                               ovr <= 1'b0;
    else if (clr_done || start)             ovr <= 1'b0;
    else if (state == DONE && enable && tick) ovr <= 1'b1;
  end
`endif

endmodule

// File: rtl/multi_channel_timeout_timer.sv
// Bank of NCH independent timeout channels with programmable terminal counts.
// Define TMR_OVERRUN_EN to expose the per-channel ovr flags.
module multi_channel_timeout_timer
  import tmr_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned CW           = 7,
  parameter int unsigned DEFAULT_TERM = 99
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NCH-1:0]         tick,
  input  logic [NCH-1:0]         start,
  input  logic [NCH-1:0]         stop,
  input  logic [NCH-1:0]         mode,
  input  logic [NCH-1:0]         clr_done,
  input  logic                   term_wr,
  input  logic [$clog2(NCH)-1:0] term_sel,
  input  logic [CW-1:0]          term_data,
`ifdef TMR_OVERRUN_EN
  output logic [NCH-1:0]         ovr,
`endif
  output logic [NCH-1:0]         timeout,
  output logic [NCH-1:0]         done,
  output logic [NCH-1:0]         busy
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr;
    // Out-of-range selects never match any channel index, so they are dropped.
    assign wr = term_wr && (int'(term_sel) == i);

    tmr_channel #(
      .CW           (CW),
      .DEFAULT_TERM (DEFAULT_TERM)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .tick      (tick[i]),
      .start     (start[i]),
      .stop      (stop[i]),
      .mode      (mode[i]),
      .clr_done  (clr_done[i]),
      .term_wr   (wr),
      .term_data (term_data),
`ifdef TMR_OVERRUN_EN
      .ovr       (ovr[i]),
`endif
      .timeout   (timeout[i]),
      .done      (done[i]),
      .busy      (busy[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_timeout_timer.sv
// Directed self-checking bench for multi_channel_timeout_timer (default parameters).
module tb_multi_channel_timeout_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] tick, start, stop, mode, clr_done;
  logic       term_wr;
  logic [1:0] term_sel;
  logic [6:0] term_data;
  logic [3:0] timeout, done, busy;
`ifdef TMR_OVERRUN_EN
  logic [3:0] ovr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_channel_timeout_timer #(
    .NCH          (4),
    .CW           (7),
    .DEFAULT_TERM (99)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .clr_done  (clr_done),
    .term_wr   (term_wr),
    .term_sel  (term_sel),
    .term_data (term_data),
`ifdef TMR_OVERRUN_EN
    .ovr       (ovr),
`endif
    .timeout   (timeout),
    .done      (done),
    .busy      (busy)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_term(input logic [1:0] sel, input logic [6:0] data);
    term_wr = 1'b1; term_sel = sel; term_data = data;
    step();
    term_wr = 1'b0;
  endtask

  int n;
  logic seen;

  initial begin
    rst = 1'b0; enable = 1'b0; tick = '0; start = '0; stop = '0; mode = '0;
    clr_done = '0; term_wr = 1'b0; term_sel = '0; term_data = '0;
    step(); step();
    chk("reset_timeout", 32'(timeout), 32'h0);
    chk("reset_done",    32'(done),    32'h0);
    chk("reset_busy",    32'(busy),    32'h0);
    rst = 1'b1;
    enable = 1'b1;

    // ch0 periodic, default term 99: pulse 100 edges after the start edge, then every 100
    start[0] = 1'b1; tick[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("t1_busy", 32'(busy[0]), 32'h1);
    n = 0;
    do begin step(); n++; end while (!timeout[0] && n < 200);
    chk("t1_first_period", 32'(n), 32'd100);
    n = 0;
    do begin step(); n++; end while (!timeout[0] && n < 200);
    chk("t1_second_period", 32'(n), 32'd100);
    step();
    chk("t1_pulse_width", 32'(timeout[0]), 32'h0);
    stop[0] = 1'b1; tick[0] = 1'b0;
    step();
    stop[0] = 1'b0;
    chk("t1_stopped", 32'(busy[0]), 32'h0);

    // ch1 one-shot, term 3: expires on the 4th tick
    wr_term(2'd1, 7'd3);
    start[1] = 1'b1; mode[1] = 1'b1;
    step();
    start[1] = 1'b0; mode[1] = 1'b0; tick[1] = 1'b1;
    step(); step(); step();
    chk("t2_pre_expiry", 32'(timeout[1]), 32'h0);
    step();
    chk("t2_timeout", 32'(timeout[1]), 32'h1);
    chk("t2_done",    32'(done[1]),    32'h1);
    chk("t2_busy",    32'(busy[1]),    32'h0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin step(); seen |= timeout[1]; end
    chk("t2_no_retrigger", 32'(seen), 32'h0);
    chk("t2_done_held", 32'(done[1]), 32'h1);
    tick[1] = 1'b0; clr_done[1] = 1'b1;
    step();
    clr_done[1] = 1'b0;
    chk("t2_clr_done", 32'(done[1]), 32'h0);
    chk("t2_idle",     32'(busy[1]), 32'h0);

    // ch2 periodic to count 50, then lower term to 10: next tick expires
    start[2] = 1'b1;
    step();
    start[2] = 1'b0; tick[2] = 1'b1;
    for (int k = 0; k < 50; k++) step();
    tick[2] = 1'b0;
    wr_term(2'd2, 7'd10);
    chk("t3_no_timeout_on_write", 32'(timeout[2]), 32'h0);
    tick[2] = 1'b1;
    step();
    chk("t3_lowered_term_expiry", 32'(timeout[2]), 32'h1);
    // count restarted at 0: 11 ticks to the next expiry
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 10) chk("t3_count_reset_pre", 32'(timeout[2]), 32'h0);
    end
    chk("t3_count_reset_expiry", 32'(timeout[2]), 32'h1);
    for (int k = 0; k < 10; k++) step();
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    chk("t3_restart_on_expiry", 32'(timeout[2]), 32'h0);
    chk("t3_restart_busy",      32'(busy[2]),    32'h1);
    for (int k = 0; k < 10; k++) step();
    start[2] = 1'b1; stop[2] = 1'b1;
    step();
    start[2] = 1'b0; stop[2] = 1'b0; tick[2] = 1'b0;
    chk("t3_stop_wins_timeout", 32'(timeout[2]), 32'h0);
    chk("t3_stop_wins_busy",    32'(busy[2]),    32'h0);

    // ch3 term 5, enable low for 20 cycles after 3 ticks
    wr_term(2'd3, 7'd5);
    start[3] = 1'b1;
    step();
    start[3] = 1'b0; tick[3] = 1'b1;
    step(); step(); step();
    enable = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin step(); seen |= timeout[3]; end
    chk("t4_frozen_no_timeout", 32'(seen), 32'h0);
    chk("t4_frozen_busy", 32'(busy[3]), 32'h1);
    enable = 1'b1;
    step(); step();
    chk("t4_delayed_pre", 32'(timeout[3]), 32'h0);
    step();
    chk("t4_delayed_expiry", 32'(timeout[3]), 32'h1);

    // reset on the edge where ch3 would expire, with ch0 running too
    start[3] = 1'b1; start[0] = 1'b1;
    step();
    start = '0; tick[0] = 1'b1;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b0;
    step();
    chk("t4_rst_timeout", 32'(timeout), 32'h0);
    chk("t4_rst_busy",    32'(busy),    32'h0);
    chk("t4_rst_done",    32'(done),    32'h0);
    rst = 1'b1; tick = '0;
    step();
    chk("t4_no_pending_timeout", 32'(timeout), 32'h0);
    // ch1 term was 3 before reset; it must be back to 99
    start[1] = 1'b1; mode[1] = 1'b1;
    step();
    start[1] = 1'b0; mode[1] = 1'b0; tick[1] = 1'b1;
    n = 0;
    do begin step(); n++; end while (!timeout[1] && n < 200);
    chk("t4_term_default", 32'(n), 32'd100);
    tick[1] = 1'b0;

`ifdef TMR_OVERRUN_EN
    wr_term(2'd0, 7'd2);
    start[0] = 1'b1; mode[0] = 1'b1;
    step();
    start[0] = 1'b0; mode[0] = 1'b0; tick[0] = 1'b1;
    step(); step(); step();
    chk("t5_done", 32'(done[0]), 32'h1);
    chk("t5_ovr_clear", 32'(ovr[0]), 32'h0);
    step();
    chk("t5_ovr_set", 32'(ovr[0]), 32'h1);
    tick[0] = 1'b0; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("t5_ovr_cleared", 32'(ovr[0]), 32'h0);
    chk("t5_done_cleared", 32'(done[0]), 32'h0);
    chk("t5_busy", 32'(busy[0]), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
